// File: rtl/byte_stream_packer_if.sv
// Byte-stream input and packed-word output bundle for byte_stream_packer.
// The slave modport is the packer's view; master is the frame source/sink side.
`timescale 1ns/1ps
interface byte_stream_packer_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic [31:0] packet4_byte;
    logic        data_valid;
    logic        last_valid;
    logic [3:0]  keep;
    logic [11:0] frame_len;
    logic        frame_len_valid;
    logic        oversize_err;

    modport slave (
        input  byte_in, byte_valid, byte_last,
        output packet4_byte, data_valid, last_valid, keep,
        output frame_len, frame_len_valid, oversize_err
    );

    modport master (
        output byte_in, byte_valid, byte_last,
        input  packet4_byte, data_valid, last_valid, keep,
        input  frame_len, frame_len_valid, oversize_err
    );
endinterface

// File: rtl/byte_stream_packer.sv
// Packs a byte-per-cycle frame stream into MSB-first 32-bit words with keep/last,
// truncating frames longer than MAX_BYTES and flagging them once the frame ends.
`timescale 1ns/1ps
module byte_stream_packer #(
    parameter int MAX_BYTES = 1522
) (
    input  logic                  clk,
    input  logic                  rst,
    byte_stream_packer_if.slave   bus
);
    localparam logic [11:0] MAX_CNT = 12'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

    state_t      r_state;
    logic [31:0] r_word;
    logic [1:0]  r_lane;
    logic [11:0] r_cnt;
    logic [31:0] r_packet;
    logic        r_data_valid;
    logic        r_last_valid;
    logic [3:0]  r_keep;
    logic [11:0] r_frame_len;
    logic        r_frame_len_valid;
    logic        r_oversize;

    logic [1:0]  w_lane;
    logic [11:0] w_cnt;
    logic [31:0] w_word;
    logic [3:0]  w_keep;
    logic        w_trunc;
    logic        w_end;
    logic        w_emit;

    // View of the byte being accepted this cycle; IDLE always restarts at lane 0, cnt 1.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        w_lane  = (r_state == IDLE) ? 2'd0 : r_lane;
        w_cnt   = (r_state == IDLE) ? 12'd1 : r_cnt + 12'd1;
        w_word  = (r_state == IDLE) ? 32'd0 : r_word;
        w_keep  = 4'b1111;
        case (w_lane)
            2'd0: begin w_word[31:24] = bus.byte_in; w_keep = 4'b0001; end
            2'd1: begin w_word[23:16] = bus.byte_in; w_keep = 4'b0011; end
            2'd2: begin w_word[15:8]  = bus.byte_in; w_keep = 4'b0111; end
            default: begin w_word[7:0] = bus.byte_in; w_keep = 4'b1111; end
        endcase
        w_trunc = !bus.byte_last && (w_cnt == MAX_CNT);
        w_end   = bus.byte_last || w_trunc;
        w_emit  = w_end || (w_lane == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= IDLE;
            r_word            <= '0;
            r_lane            <= '0;
            r_cnt             <= '0;
            r_packet          <= '0;
            r_data_valid      <= 1'b0;
            r_last_valid      <= 1'b0;
            r_keep            <= '0;
            r_frame_len       <= '0;
            r_frame_len_valid <= 1'b0;
            r_oversize        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_packet          <= '0;
            r_data_valid      <= 1'b0;
            r_last_valid      <= 1'b0;
            r_keep            <= '0;
            r_frame_len_valid <= 1'b0;
            r_oversize        <= 1'b0;
            case (r_state)
                IDLE, PACK: begin
                    if (bus.byte_valid) begin
                        r_cnt <= w_cnt;
                        if (w_emit) begin
                            r_packet     <= w_word;
                            r_keep       <= w_keep;
                            r_data_valid <= 1'b1;
                            r_last_valid <= w_end;
                            r_word       <= '0;
                            r_lane       <= '0;
                        end else begin
                            r_word <= w_word;
                            r_lane <= w_lane + 2'd1;
                        end
                        if (w_end) begin
                            r_frame_len       <= w_cnt;
                            r_frame_len_valid <= 1'b1;
                        end
                        r_state <= bus.byte_last ? IDLE : (w_trunc ? DROP : PACK);
                    end
                end
                DROP: begin
                    if (bus.byte_valid && bus.byte_last) begin
                        r_oversize <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.packet4_byte    = r_packet;
    assign bus.data_valid      = r_data_valid;
    assign bus.last_valid      = r_last_valid;
    assign bus.keep            = r_keep;
    assign bus.frame_len       = r_frame_len;
    assign bus.frame_len_valid = r_frame_len_valid;
    assign bus.oversize_err    = r_oversize;
endmodule
